// File: rtl/audio_record_ctrl.sv
// Recorder/player sequencer: one sample RAM access per codec LR-clock frame,
// record into RAM, play back to the DAC path, with stop/loop/full handling.
`timescale 1ns/1ps
module audio_record_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 24000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iLRCK,
  input  logic              iREC_REQ,
  input  logic              iPLAY_REQ,
  input  logic              iSTOP_REQ,
  input  logic              iLOOP,
  input  logic [DATA_W-1:0] iADC_L,
  output logic [ADDR_W-1:0] oMEM_ADDR,
  output logic [DATA_W-1:0] oMEM_WDATA,
  output logic              oMEM_WE,
  output logic              oMEM_RE,
  input  logic [DATA_W-1:0] iMEM_RDATA,
  output logic [DATA_W-1:0] oDAC_L,
  output logic [1:0]        oSTATE,
  output logic [ADDR_W:0]   oLEN,
  output logic              oFULL,
  output logic              oDONE
);
  // state | meaning
  // IDLE  | waiting for a request, DAC muted
  // REC   | one RAM write per LRCK frame until STOP or RAM full
  // PLAY  | one RAM read per LRCK frame, sample presented on oDAC_L
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     len;
  logic                full, done, we, re;
  logic                rd_vld, last_rd, play_end;
  logic [DATA_W-1:0]   dac;
  logic                lrck_s1, lrck_s2, lrck_d;
  logic                tick;
  logic                done_nxt, we_nxt, re_nxt;
  logic                start_rec, start_play, full_set, go_idle;
  logic                is_last_wr, is_last_rd;

  assign tick       = lrck_s2 & ~lrck_d;
  assign is_last_wr = (addr == ADDR_LAST);
  assign is_last_rd = ({1'b0, addr} == (len - LEN_ONE));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    done_nxt   = 1'b0;
    we_nxt     = 1'b0;
    re_nxt     = 1'b0;
    start_rec  = 1'b0;
    start_play = 1'b0;
    full_set   = 1'b0;
    go_idle    = 1'b0;
    case (state)
      S_IDLE: begin
        // STOP has nothing to stop here, so REC then PLAY decide
        if (iREC_REQ) begin
          state_nxt = S_REC;
          start_rec = 1'b1;
        end else if (iPLAY_REQ) begin
          if (len != '0) begin
            state_nxt  = S_PLAY;
            start_play = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_REC: begin
        if (iSTOP_REQ) begin
          go_idle = 1'b1;
        end else if (we && is_last_wr) begin
          go_idle  = 1'b1;
          full_set = 1'b1;
        end else if (tick && !we) begin
          we_nxt = 1'b1;
        end
      end
      S_PLAY: begin
        if (iSTOP_REQ || play_end) begin
          go_idle = 1'b1;
        end else if (tick && !re && !last_rd) begin
          re_nxt = 1'b1;
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      lrck_s1  <= 1'b0;
      lrck_s2  <= 1'b0;
      lrck_d   <= 1'b0;
      addr     <= '0;
      len      <= '0;
      full     <= 1'b0;
      done     <= 1'b0;
      we       <= 1'b0;
      re       <= 1'b0;
      rd_vld   <= 1'b0;
      last_rd  <= 1'b0;
      play_end <= 1'b0;
      dac      <= '0;
    end else begin
      lrck_s1 <= iLRCK;
      lrck_s2 <= lrck_s1;
      lrck_d  <= lrck_s2;
      done    <= done_nxt;
      we      <= we_nxt;
      re      <= re_nxt;

      // a write already on the bus still counts even if STOP lands with it
      if (start_rec) begin
        addr <= '0;
        len  <= '0;
        full <= 1'b0;
      end else if (start_play) begin
        addr <= '0;
      end else if (we) begin
        addr <= addr + ADDR_ONE;
        len  <= {1'b0, addr} + LEN_ONE;
      end else if (re) begin
        addr <= (is_last_rd && iLOOP) ? '0 : addr + ADDR_ONE;
      end
      if (full_set) full <= 1'b1;

      rd_vld <= re && (state_nxt == S_PLAY);
      if (state_nxt != S_PLAY)              last_rd <= 1'b0;
      else if (re && is_last_rd && !iLOOP)  last_rd <= 1'b1;
      // hold PLAY one extra cycle so the final sample is actually shown
      play_end <= rd_vld && last_rd && (state_nxt == S_PLAY);

      if (state_nxt != S_PLAY) dac <= '0;
      else if (rd_vld)         dac <= iMEM_RDATA;
    end
  end

  assign oMEM_ADDR  = addr;
  assign oMEM_WDATA = iADC_L;
  assign oMEM_WE    = we;
  assign oMEM_RE    = re;
  assign oDAC_L     = dac;
  assign oSTATE     = state;
  assign oLEN       = len;
  assign oFULL      = full;
  assign oDONE      = done;

endmodule

// File: tb/tb_audio_record_ctrl.sv
// Scoreboard bench for audio_record_ctrl: a full-depth instance and a DEPTH=8
// instance share clock, reset, LRCK, ADC and loop; requests are per instance.
`timescale 1ns/1ps
module tb_audio_record_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrck = 1'b0;
  logic        rec_req = 1'b0, play_req = 1'b0, stop_req = 1'b0;
  logic        rec8 = 1'b0, play8 = 1'b0, stop8 = 1'b0;
  logic        loop = 1'b0;
  logic [15:0] adc = '0;

  logic [14:0] addr0, addr8;
  logic [15:0] wdata0, wdata8, rdata0, rdata8, dac0, dac8;
  logic        we0, we8, re0, re8, full0, full8, done0, done8;
  logic [1:0]  state0, state8;
  logic [15:0] len0, len8;

  logic [15:0] mem0 [0:32767];
  logic [15:0] mem8 [0:32767];

  logic [30:0] wq0[$], wq8[$];
  logic [14:0] rq0[$], rq8[$];
  logic [15:0] dq0[$], dq8[$];
  int          n_checks = 0, n_pass = 0;
  int          done_cnt0 = 0, done_cnt8 = 0;

  always #5 clk = ~clk;

  audio_record_ctrl dut (
    .iCLK(clk), .iRST_N(rst_n), .iLRCK(lrck),
    .iREC_REQ(rec_req), .iPLAY_REQ(play_req), .iSTOP_REQ(stop_req),
    .iLOOP(loop), .iADC_L(adc),
    .oMEM_ADDR(addr0), .oMEM_WDATA(wdata0), .oMEM_WE(we0), .oMEM_RE(re0),
    .iMEM_RDATA(rdata0), .oDAC_L(dac0), .oSTATE(state0), .oLEN(len0),
    .oFULL(full0), .oDONE(done0)
  );

  audio_record_ctrl #(.DATA_W(16), .ADDR_W(15), .DEPTH(8)) dut8 (
    .iCLK(clk), .iRST_N(rst_n), .iLRCK(lrck),
    .iREC_REQ(rec8), .iPLAY_REQ(play8), .iSTOP_REQ(stop8),
    .iLOOP(loop), .iADC_L(adc),
    .oMEM_ADDR(addr8), .oMEM_WDATA(wdata8), .oMEM_WE(we8), .oMEM_RE(re8),
    .iMEM_RDATA(rdata8), .oDAC_L(dac8), .oSTATE(state8), .oLEN(len8),
    .oFULL(full8), .oDONE(done8)
  );

  // synchronous RAMs with one-cycle read latency
  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wdata0;
    if (re0) rdata0 <= mem0[addr0];
    if (we8) mem8[addr8] <= wdata8;
    if (re8) rdata8 <= mem8[addr8];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic monitor();
    int          pend0 = 0, pend8 = 0;
    logic [15:0] pv0 = '0, pv8 = '0;
    logic [30:0] ew;
    logic [14:0] ea;
    forever begin
      @(negedge clk);
      if (pend0 > 0) begin
        pend0--;
        if (pend0 == 0) begin
          n_checks++;
          if (dac0 !== pv0) $display("FAIL dac0: got %0h expected %0h", dac0, pv0);
          else n_pass++;
        end
      end
      if (pend8 > 0) begin
        pend8--;
        if (pend8 == 0) begin
          n_checks++;
          if (dac8 !== pv8) $display("FAIL dac8: got %0h expected %0h", dac8, pv8);
          else n_pass++;
        end
      end
      if (done0) done_cnt0++;
      if (done8) done_cnt8++;
      if (we0 || re0) begin
        n_checks++;
        if (we0 && re0) $display("FAIL we_re_excl0: got we=1 re=1 expected one");
        else n_pass++;
      end
      if (we0) begin
        n_checks++;
        if (wq0.size() == 0) $display("FAIL write0: got write at %0d expected none", addr0);
        else begin
          ew = wq0.pop_front();
          if ({addr0, wdata0} !== ew)
            $display("FAIL write0: got %0d/%0h expected %0d/%0h", addr0, wdata0, ew[30:16], ew[15:0]);
          else n_pass++;
        end
      end
      if (re0) begin
        n_checks++;
        if (rq0.size() == 0 || dq0.size() == 0) $display("FAIL read0: got read at %0d expected none", addr0);
        else begin
          ea = rq0.pop_front();
          pv0 = dq0.pop_front();
          pend0 = 2;
          if (addr0 !== ea) $display("FAIL read0: got addr %0d expected %0d", addr0, ea);
          else n_pass++;
        end
      end
      if (we8) begin
        n_checks++;
        if (wq8.size() == 0) $display("FAIL write8: got write at %0d expected none", addr8);
        else begin
          ew = wq8.pop_front();
          if ({addr8, wdata8} !== ew)
            $display("FAIL write8: got %0d/%0h expected %0d/%0h", addr8, wdata8, ew[30:16], ew[15:0]);
          else n_pass++;
        end
      end
      if (re8) begin
        n_checks++;
        if (rq8.size() == 0 || dq8.size() == 0) $display("FAIL read8: got read at %0d expected none", addr8);
        else begin
          ea = rq8.pop_front();
          pv8 = dq8.pop_front();
          pend8 = 2;
          if (addr8 !== ea) $display("FAIL read8: got addr %0d expected %0d", addr8, ea);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic frame(input logic [15:0] v);
    adc  = v;
    lrck = 1'b1;
    repeat (5) @(negedge clk);
    lrck = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({state0, we0, re0, dac0, len0, full0, done0, addr0} !== '0)
      $display("FAIL reset_init: got st=%0d len=%0d addr=%0d dac=%0h expected 0", state0, len0, addr0, dac0);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    rec_req = 1'b1; @(negedge clk); rec_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b01) $display("FAIL rec_enter: got %0d expected 1", state0); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      wq0.push_back({15'(i), 16'(32'h1000 + i)});
      frame(16'(32'h1000 + i));
    end
    n_checks++;
    if (addr0 !== 15'd100 || len0 !== 16'd100)
      $display("FAIL rec_100: got addr=%0d len=%0d expected 100/100", addr0, len0);
    else n_pass++;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({state0, we0, re0, dac0, len0, full0, done0, addr0} !== '0)
      $display("FAIL reset_async: got st=%0d len=%0d addr=%0d expected 0", state0, len0, addr0);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    n_checks++;
    if (state0 !== 2'b00 || len0 !== 16'd0)
      $display("FAIL reset_release: got st=%0d len=%0d expected 0/0", state0, len0);
    else n_pass++;
  endtask

  task automatic test_record_stop();
    int d0 = done_cnt0;
    rec_req = 1'b1; @(negedge clk); rec_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b01 || len0 !== 16'd0)
      $display("FAIL rs_start: got st=%0d len=%0d expected 1/0", state0, len0);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      wq0.push_back({15'(i), 16'(i + 1)});
      frame(16'(i + 1));
    end
    stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b00 || done0 !== 1'b1)
      $display("FAIL rs_stop: got st=%0d done=%0d expected 0/1", state0, done0);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt0 - d0 !== 1 || len0 !== 16'd10 || full0 !== 1'b0)
      $display("FAIL rs_end: got done=%0d len=%0d full=%0d expected 1/10/0", done_cnt0 - d0, len0, full0);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (mem0[i] !== 16'(i + 1)) $display("FAIL rs_ram[%0d]: got %0h expected %0h", i, mem0[i], i + 1);
      else n_pass++;
    end
    n_checks++;
    if (wq0.size() != 0) $display("FAIL rs_writes: got %0d outstanding expected 0", wq0.size());
    else n_pass++;
  endtask

  task automatic test_playback();
    int d0 = done_cnt0;
    loop = 1'b0;
    play_req = 1'b1; @(negedge clk); play_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b10) $display("FAIL pb_start: got %0d expected 2", state0); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      rq0.push_back(15'(i));
      dq0.push_back(16'(i + 1));
      frame(16'hbeef);
    end
    n_checks++;
    if (state0 !== 2'b00 || dac0 !== 16'd0 || done_cnt0 - d0 !== 1 || rq0.size() != 0)
      $display("FAIL pb_end: got st=%0d dac=%0h done=%0d left=%0d expected 0/0/1/0",
               state0, dac0, done_cnt0 - d0, rq0.size());
    else n_pass++;
  endtask

  task automatic test_full_loop();
    int d8 = done_cnt8;
    rec8 = 1'b1; @(negedge clk); rec8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) wq8.push_back({15'(i), 16'(50 + i)});
      frame(16'(50 + i));
    end
    n_checks++;
    if (state8 !== 2'b00 || len8 !== 16'd8 || full8 !== 1'b1 || done_cnt8 - d8 !== 1 || wq8.size() != 0)
      $display("FAIL full: got st=%0d len=%0d full=%0d done=%0d expected 0/8/1/1",
               state8, len8, full8, done_cnt8 - d8);
    else n_pass++;
    loop = 1'b1;
    play8 = 1'b1; @(negedge clk); play8 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rq8.push_back(15'(i % 8));
      dq8.push_back(16'(50 + i % 8));
      frame(16'h0);
    end
    n_checks++;
    if (state8 !== 2'b10 || rq8.size() != 0)
      $display("FAIL loop: got st=%0d left=%0d expected 2/0", state8, rq8.size());
    else n_pass++;
    stop8 = 1'b1; @(negedge clk); stop8 = 1'b0;
    loop = 1'b0;
    n_checks++;
    if (state8 !== 2'b00 || dac8 !== 16'd0)
      $display("FAIL loop_stop: got st=%0d dac=%0h expected 0/0", state8, dac8);
    else n_pass++;
    rec8 = 1'b1; @(negedge clk); rec8 = 1'b0;
    n_checks++;
    if (state8 !== 2'b01 || full8 !== 1'b0 || len8 !== 16'd0)
      $display("FAIL full_clear: got st=%0d full=%0d len=%0d expected 1/0/0", state8, full8, len8);
    else n_pass++;
    stop8 = 1'b1; @(negedge clk); stop8 = 1'b0;
  endtask

  task automatic test_collisions();
    rec_req = 1'b1; play_req = 1'b1; stop_req = 1'b1;
    @(negedge clk);
    rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b01) $display("FAIL col_prio: got %0d expected 1", state0); else n_pass++;
    stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
    play_req = 1'b1; @(negedge clk); play_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b00 || done0 !== 1'b1 || len0 !== 16'd0)
      $display("FAIL col_empty_play: got st=%0d done=%0d len=%0d expected 0/1/0", state0, done0, len0);
    else n_pass++;
    rec_req = 1'b1; @(negedge clk); rec_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wq0.push_back({15'(i), 16'(7 + i)});
      frame(16'(7 + i));
    end
    stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
    play_req = 1'b1; @(negedge clk); play_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rq0.push_back(15'(i));
      dq0.push_back(16'(7 + i));
      frame(16'h0);
    end
    n_checks++;
    if (dac0 !== 16'd8) $display("FAIL col_hold: got %0h expected 8", dac0); else n_pass++;
    // LRCK rises now; the resulting tick is sampled two edges later together with STOP
    lrck = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    n_checks++;
    if (state0 !== 2'b00 || re0 !== 1'b0 || done0 !== 1'b1 || dac0 !== 16'd0)
      $display("FAIL col_stop_tick: got st=%0d re=%0d done=%0d dac=%0h expected 0/0/1/0",
               state0, re0, done0, dac0);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (re0 !== 1'b0 || dac0 !== 16'd0)
      $display("FAIL col_after: got re=%0d dac=%0h expected 0/0", re0, dac0);
    else n_pass++;
    lrck = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++;
    if (len0 !== 16'd3 || rq0.size() != 0)
      $display("FAIL col_len: got len=%0d left=%0d expected 3/0", len0, rq0.size());
    else n_pass++;
  endtask

  task automatic test_lrck_sync();
    rec_req = 1'b1; @(negedge clk); rec_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      adc = 16'(32'h2000 + i);
      wq0.push_back({15'(i), 16'(32'h2000 + i)});
      #($urandom_range(1, 9));
      lrck = 1'b1;
      repeat ($urandom_range(3, 5)) @(negedge clk);
      #($urandom_range(1, 9));
      lrck = 1'b0;
      repeat ($urandom_range(6, 9)) @(negedge clk);
    end
    @(negedge clk);
    stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
    n_checks++;
    if (len0 !== 16'd16 || wq0.size() != 0 || state0 !== 2'b00)
      $display("FAIL sync: got len=%0d left=%0d st=%0d expected 16/0/0", len0, wq0.size(), state0);
    else n_pass++;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_record_stop();
    test_playback();
    test_full_loop();
    test_collisions();
    test_lrck_sync();
    repeat (4) @(negedge clk);
    n_checks++;
    if (wq0.size() + rq0.size() + wq8.size() + rq8.size() != 0)
      $display("FAIL outstanding: got %0d expected 0", wq0.size() + rq0.size() + wq8.size() + rq8.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/audio_record_ctrl.md
# audio_record_ctrl

Sequences the 16-bit sample memory of the audio recorder: in record mode it writes one ADC sample per audio frame, in playback mode it reads samples back and presents them to the DAC path. It sits between the audio converter (sample in/out), the board controls (record/play/stop) and the sample RAM, and is the only master of that RAM. Frame timing comes from the codec LR clock, which the block synchronizes and edge-detects internally.

## Interface
- DATA_W, 16, sample width.
- ADDR_W, 15, memory address width.
- DEPTH, 24000, number of sample locations, at most 2^ADDR_W.

- iCLK  in  1  system clock (50 MHz); all logic on rising edge.
- iRST_N  in  1  reset, asynchronous, active-low.
- iLRCK  in  1  codec LR clock, asynchronous to iCLK.
- iREC_REQ  in  1  one-cycle pulse: start recording.
- iPLAY_REQ  in  1  one-cycle pulse: start playback.
- iSTOP_REQ  in  1  one-cycle pulse: stop the active operation.
- iLOOP  in  1  level: when high, playback restarts at address 0 after the last sample.
- iADC_L  in  DATA_W  current left-channel ADC sample.
- oMEM_ADDR  out  ADDR_W  RAM address.
- oMEM_WDATA  out  DATA_W  RAM write data.
- oMEM_WE  out  1  RAM write strobe, one cycle per write.
- oMEM_RE  out  1  RAM read strobe, one cycle per read.
- iMEM_RDATA  in  DATA_W  RAM read data, valid the cycle after oMEM_RE.
- oDAC_L  out  DATA_W  playback sample to the DAC path.
- oSTATE  out  2  00 IDLE, 01 REC, 10 PLAY.
- oLEN  out  ADDR_W+1  number of valid recorded samples.
- oFULL  out  1  high while the last recording filled DEPTH; cleared by the next REC start.
- oDONE  out  1  one-cycle pulse when REC or PLAY ends for any reason.

## Operation
- LRCK path: 2-flop synchronizer, then rising-edge detect. This produces a one-cycle `tick` per audio frame.
- IDLE:
  - Accept requests with priority STOP > REC > PLAY. STOP in IDLE is a no-op.
  - REC: go to REC with addr=0, oLEN=0, oFULL=0.
  - PLAY with oLEN≠0: go to PLAY with addr=0.
  - PLAY with oLEN=0: stay IDLE and pulse oDONE.
- REC:
  - On tick, write iADC_L at addr, then addr++ and oLEN=addr+1.
  - After the write at addr=DEPTH-1: go to IDLE, set oFULL=1, pulse oDONE.
- PLAY:
  - On tick, assert oMEM_RE at addr, then addr++.
  - After the read at addr=oLEN-1:
    - if iLOOP=1, addr wraps to 0 and PLAY continues;
    - otherwise, once that last sample reaches oDAC_L, go to IDLE and pulse oDONE.
- In REC or PLAY, only iSTOP_REQ is honoured. iREC_REQ and iPLAY_REQ are ignored.
- STOP in REC or PLAY: go to IDLE and pulse oDONE. oLEN keeps the count of samples written so far.
- STOP and tick in the same cycle: STOP wins. No write or read is issued that cycle.
- Outside PLAY, oDAC_L is 0 (mute). On entry to IDLE, any in-flight read data is discarded and oDAC_L is forced to 0.
- oMEM_ADDR shows addr at all times. oMEM_WDATA follows iADC_L.

## Timing
- Reset values: state IDLE, addr 0, oLEN 0, oFULL 0, oDONE 0, oMEM_WE 0, oMEM_RE 0, oDAC_L 0, synchronizer flops 0.
- Deasserting reset mid-operation always resumes in IDLE; RAM contents are not touched.
- tick occurs 3 iCLK cycles after an iLRCK rising edge (±1 for synchronizer metastability).
- Request latency: a request pulse in cycle N changes oSTATE in cycle N+1.
- Write: oMEM_WE is high in the cycle after tick, with that cycle's addr and data. addr increments in the following cycle.
- Read:
  - oMEM_RE is high in the cycle after tick;
  - iMEM_RDATA is sampled one cycle later;
  - oDAC_L updates the cycle after that, i.e. 3 cycles after tick;
  - oDAC_L then holds until the next update.
- oDONE goes high in the same cycle oSTATE returns to 00.
- At most one RAM access per tick; oMEM_WE and oMEM_RE are never high together.

## Test plan
- Reset: assert iRST_N=0 mid-REC at addr 100 → all outputs return to reset values immediately. After release, oSTATE=00 and oLEN=0.
- Record then stop: REC pulse, 10 LRCK frames with iADC_L=frame index 1..10, then STOP → RAM[0..9]=1..10, oLEN=10, one oDONE pulse, oFULL=0.
- Playback: after the recording above, PLAY with iLOOP=0 → oDAC_L=1..10, each 3 cycles after its tick. Then oDAC_L=0, oSTATE=00, one oDONE pulse.
- Full and loop:
  - Set DEPTH=8 and record 12 frames → exactly 8 writes, oLEN=8, oFULL=1, automatic return to IDLE.
  - PLAY with iLOOP=1 for 20 frames → address sequence 0..7,0..7,0..3.
- Collisions:
  - REC, PLAY and STOP in the same cycle in IDLE → enters REC.
  - STOP coinciding with tick in PLAY → no oMEM_RE, oDAC_L=0 next cycle.
  - PLAY with oLEN=0 → oDONE pulse, oSTATE stays 00.
- LRCK sync: apply iLRCK edges with random phase relative to iCLK → exactly one tick per rising edge, and no RAM access without a tick.
